// File: rtl/register_dot_product_sequencer.sv
// register_dot_product_sequencer
//
// Computes the signed 8-bit dot product of two vectors held in an external
// register file. It then writes the result, saturated to 8 bits, back into
// that register file.
//
// Sequence: IDLE -> ACCUMULATE (length cycles) -> WRITEBACK (1) -> DONE (1).
// A zero-length request skips ACCUMULATE and goes straight to WRITEBACK.
//
// Ports
//   clock_in                    single clock, rising edge
//   reset_n_in                  synchronous, active-low reset
//   start_in                    request; sampled only in IDLE
//   vector_a_base_address_in    first register of vector A
//   vector_b_base_address_in    first register of vector B
//   result_address_in           register that receives the saturated result
//   length_in                   element count, 0..NUMBER_OF_REGISTERS
//   read_register_address1_out  read port 1 address (vector A)
//   read_register_address2_out  read port 2 address (vector B)
//   read_data1_in/2_in          combinational read data, same cycle as address
//   write_enable_out            write strobe (WRITEBACK only)
//   write_register_address_out  write address
//   write_data_out              write data
//   busy_out                    high in every state except IDLE
//   done_out                    one-cycle completion pulse
//   result_out                  full-precision signed dot product
module register_dot_product_sequencer #(
  parameter int NUMBER_OF_REGISTERS = 256,
  parameter int ACCUMULATOR_WIDTH   = 24,
  localparam int ADDR_W             = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                         clock_in,
  input  logic                         reset_n_in,
  input  logic                         start_in,
  input  logic [ADDR_W-1:0]            vector_a_base_address_in,
  input  logic [ADDR_W-1:0]            vector_b_base_address_in,
  input  logic [ADDR_W-1:0]            result_address_in,
  input  logic [ADDR_W:0]              length_in,
  output logic [ADDR_W-1:0]            read_register_address1_out,
  output logic [ADDR_W-1:0]            read_register_address2_out,
  input  logic [7:0]                   read_data1_in,
  input  logic [7:0]                   read_data2_in,
  output logic                         write_enable_out,
  output logic [ADDR_W-1:0]            write_register_address_out,
  output logic [7:0]                   write_data_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic [ACCUMULATOR_WIDTH-1:0] result_out
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACCUMULATE = 2'd1,
    WRITEBACK  = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] NREG = (ADDR_W+1)'(NUMBER_OF_REGISTERS);
  localparam logic signed [ACCUMULATOR_WIDTH-1:0] SAT_MAX = 127;
  localparam logic signed [ACCUMULATOR_WIDTH-1:0] SAT_MIN = -128;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0]                   a_base_reg;
  logic [ADDR_W-1:0]                   b_base_reg;
  logic [ADDR_W-1:0]                   result_addr_reg;
  logic [ADDR_W:0]                     length_reg;
  logic [ADDR_W:0]                     count_reg;
  logic signed [ACCUMULATOR_WIDTH-1:0] acc_reg;
  logic [ACCUMULATOR_WIDTH-1:0]        result_reg;

  // Element addresses. Base and offset are each below NUMBER_OF_REGISTERS,
  // so their sum is below 2*NUMBER_OF_REGISTERS. A single conditional
  // subtract therefore gives the modulo, even for depths that are not a
  // power of two.
  logic [ADDR_W:0]   addr1_sum, addr2_sum;
  logic [ADDR_W-1:0] addr1_wrap, addr2_wrap;

  always_comb begin
    addr1_sum  = {1'b0, a_base_reg} + {1'b0, count_reg[ADDR_W-1:0]};
    addr2_sum  = {1'b0, b_base_reg} + {1'b0, count_reg[ADDR_W-1:0]};
    addr1_wrap = (addr1_sum >= NREG) ? ADDR_W'(addr1_sum - NREG) : addr1_sum[ADDR_W-1:0];
    addr2_wrap = (addr2_sum >= NREG) ? ADDR_W'(addr2_sum - NREG) : addr2_sum[ADDR_W-1:0];
  end

  // 8x8 signed product, sign-extended to the accumulator width.
  logic signed [15:0]                  product;
  logic signed [ACCUMULATOR_WIDTH-1:0] product_ext;

  always_comb begin
    product     = $signed(read_data1_in) * $signed(read_data2_in);
    product_ext = {{(ACCUMULATOR_WIDTH-16){product[15]}}, product};
  end

  // Saturate the accumulator to the 8-bit register range.
  logic [7:0] sat_byte;

  always_comb begin
    if (acc_reg > SAT_MAX)
      sat_byte = 8'h7F;
    else if (acc_reg < SAT_MIN)
      sat_byte = 8'h80;
    else
      sat_byte = acc_reg[7:0];
  end

  // State register
  always_ff @(posedge clock_in) begin
    if (!reset_n_in)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_in)
          state_next = (length_in != '0) ? ACCUMULATE : WRITEBACK;
      end
      ACCUMULATE: begin
        if (count_reg == length_reg - (ADDR_W+1)'(1))
          state_next = WRITEBACK;
      end
      WRITEBACK: state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      a_base_reg      <= '0;
      b_base_reg      <= '0;
      result_addr_reg <= '0;
      length_reg      <= '0;
      count_reg       <= '0;
      acc_reg         <= '0;
      result_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_in) begin
            a_base_reg      <= vector_a_base_address_in;
            b_base_reg      <= vector_b_base_address_in;
            result_addr_reg <= result_address_in;
            length_reg      <= length_in;
            count_reg       <= '0;
            acc_reg         <= '0;
          end
        end
        ACCUMULATE: begin
          acc_reg   <= acc_reg + product_ext;
          count_reg <= count_reg + (ADDR_W+1)'(1);
        end
        // The edge leaving WRITEBACK is the DONE entry edge.
        WRITEBACK: result_reg <= acc_reg;
        default: ;
      endcase
    end
  end

  assign result_out = result_reg;

  // Outputs are decoded from state only. Reset forces IDLE, so reset
  // also forces every output to its IDLE value (all zero).
  always_comb begin
    busy_out                   = 1'b1;
    done_out                   = 1'b0;
    write_enable_out           = 1'b0;
    write_register_address_out = '0;
    write_data_out             = '0;
    read_register_address1_out = '0;
    read_register_address2_out = '0;
    case (state_reg)
      IDLE: busy_out = 1'b0;
      ACCUMULATE: begin
        read_register_address1_out = addr1_wrap;
        read_register_address2_out = addr2_wrap;
      end
      WRITEBACK: begin
        write_enable_out           = 1'b1;
        write_register_address_out = result_addr_reg;
        write_data_out             = sat_byte;
      end
      DONE: done_out = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_register_dot_product_sequencer.sv
// Directed testbench for register_dot_product_sequencer.
// The bench models the register file: reads are combinational and writes
// are committed as they are observed.
module tb_register_dot_product_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a_base = '0;
  logic [7:0]  b_base = '0;
  logic [7:0]  r_addr = '0;
  logic [8:0]  len = '0;
  logic [7:0]  addr1, addr2, waddr, wdata;
  logic [7:0]  rd1, rd2;
  logic        we, busy, done;
  logic [23:0] result;

  logic [7:0] regs [256];

  int total = 0;
  int bad = 0;
  int addr1_q[$];
  int addr2_q[$];
  int dcyc, nw;

  always #5 clk = ~clk;

  assign rd1 = regs[addr1];
  assign rd2 = regs[addr2];

  register_dot_product_sequencer dut (
    .clock_in                   (clk),
    .reset_n_in                 (reset_n),
    .start_in                   (start),
    .vector_a_base_address_in   (a_base),
    .vector_b_base_address_in   (b_base),
    .result_address_in          (r_addr),
    .length_in                  (len),
    .read_register_address1_out (addr1),
    .read_register_address2_out (addr2),
    .read_data1_in              (rd1),
    .read_data2_in              (rd2),
    .write_enable_out           (we),
    .write_register_address_out (waddr),
    .write_data_out             (wdata),
    .busy_out                   (busy),
    .done_out                   (done),
    .result_out                 (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation: the start is accepted at edge 0, then the bench
  // runs until done_out. With disturb set, a second start carrying
  // different operands is pulsed during ACCUMULATE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                        input logic [8:0] l, input bit disturb,
                        output int done_cycle, output int nwrites);
    addr1_q.delete();
    addr2_q.delete();
    a_base = a; b_base = b; r_addr = r; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cycle = -1;
    nwrites = 0;
    for (int c = 1; c <= 600; c++) begin
      if (we) begin
        regs[waddr] = wdata;
        nwrites++;
      end
      if (busy && !we && !done) begin
        addr1_q.push_back(int'(addr1));
        addr2_q.push_back(int'(addr2));
      end
      if (done) begin
        done_cycle = c;
        break;
      end
      if (disturb && c == 2) begin
        start = 1'b1; a_base = 8'd100; b_base = 8'd100; len = 9'd1; r_addr = 8'd22;
      end
      if (disturb && c == 3) start = 1'b0;
      @(posedge clk); #1;
    end
    check("no_timeout", 32'(done_cycle > 0), 32'd1);
    $display("op A=%0d B=%0d R=%0d L=%0d -> result=%0h done_cycle=%0d writes=%0d",
             a, b, r, l, result, done_cycle, nwrites);
    @(posedge clk); #1;
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;

    // Reset
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_addr", {8'd0, addr1, addr2, waddr}, 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic dot product: 1*5+2*6+3*7+4*8 = 70
    regs[0] = 8'd1; regs[1] = 8'd2; regs[2] = 8'd3; regs[3] = 8'd4;
    regs[8] = 8'd5; regs[9] = 8'd6; regs[10] = 8'd7; regs[11] = 8'd8;
    run_op(8'd0, 8'd8, 8'd20, 9'd4, 1'b0, dcyc, nw);
    check("basic_result", 32'(result), 32'd70);
    check("basic_reg20", 32'(regs[20]), 32'd70);
    check("basic_done_cycle", 32'(dcyc), 32'd6);
    check("basic_writes", 32'(nw), 32'd1);
    check("basic_addr1_seq", 32'(addr1_q.size() == 4 && addr1_q[0] == 0 && addr1_q[3] == 3), 32'd1);
    check("basic_addr2_seq", 32'(addr2_q.size() == 4 && addr2_q[0] == 8 && addr2_q[3] == 11), 32'd1);

    // Saturate high: (-128)*(-128)*2 = 32768 -> 0x7F
    regs[0] = 8'h80; regs[1] = 8'h80; regs[2] = 8'h80; regs[3] = 8'h80;
    run_op(8'd0, 8'd2, 8'd30, 9'd2, 1'b0, dcyc, nw);
    check("sathi_result", 32'(result), 32'h008000);
    check("sathi_byte", 32'(regs[30]), 32'h7F);

    // Saturate low: (-128)*127*2 = -32512 -> 0x80
    regs[4] = 8'h7F; regs[5] = 8'h7F;
    run_op(8'd0, 8'd4, 8'd31, 9'd2, 1'b0, dcyc, nw);
    check("satlo_result", 32'(result), 32'h00FF8100);
    check("satlo_byte", 32'(regs[31]), 32'h80);

    // Wrap-around: 3*10 + (-2)*20 + 7*(-5) + (-7)*4 = -73 (0xB7)
    regs[254] = 8'd3; regs[255] = 8'hFE; regs[0] = 8'd7; regs[1] = 8'hF9;
    regs[100] = 8'd10; regs[101] = 8'd20; regs[102] = 8'hFB; regs[103] = 8'd4;
    run_op(8'd254, 8'd100, 8'd40, 9'd4, 1'b0, dcyc, nw);
    check("wrap_addr1_seq", 32'(addr1_q.size() == 4 && addr1_q[0] == 254 && addr1_q[1] == 255
                                && addr1_q[2] == 0 && addr1_q[3] == 1), 32'd1);
    check("wrap_result", 32'(result), 32'h00FFFFB7);
    check("wrap_byte", 32'(regs[40]), 32'hB7);

    // Zero length
    regs[5] = 8'h55;
    run_op(8'd0, 8'd8, 8'd5, 9'd0, 1'b0, dcyc, nw);
    check("zero_reg5", 32'(regs[5]), 32'd0);
    check("zero_result", 32'(result), 32'd0);
    check("zero_done_cycle", 32'(dcyc), 32'd2);
    check("zero_no_reads", 32'(addr1_q.size()), 32'd0);

    // Start pulsed during ACCUMULATE is ignored
    regs[0] = 8'd1; regs[1] = 8'd2; regs[2] = 8'd3; regs[3] = 8'd4;
    regs[22] = 8'h33;
    run_op(8'd0, 8'd8, 8'd21, 9'd4, 1'b1, dcyc, nw);
    check("ignore_result", 32'(result), 32'd70);
    check("ignore_reg21", 32'(regs[21]), 32'd70);
    check("ignore_reg22", 32'(regs[22]), 32'h33);
    check("ignore_done_cycle", 32'(dcyc), 32'd6);
    check("ignore_writes", 32'(nw), 32'd1);

    // Reset during the second ACCUMULATE cycle aborts the operation
    regs[23] = 8'h44;
    nw = 0;
    a_base = 8'd0; b_base = 8'd8; r_addr = 8'd23; len = 9'd4; start = 1'b1;
    @(posedge clk); #1;                 // cycle 1: first ACCUMULATE
    start = 1'b0;
    if (we) nw++;
    @(posedge clk); #1;                 // cycle 2: second ACCUMULATE
    if (we) nw++;
    reset_n = 1'b0;
    @(posedge clk); #1;                 // cycle 3: after the reset edge
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(we), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (we || done) nw++;
      @(posedge clk); #1;
    end
    check("abort_no_write", 32'(nw), 32'd0);
    check("abort_reg23", 32'(regs[23]), 32'h44);
    $display("op abort R=23 -> busy=%0d result=%0h writes=%0d", busy, result, nw);

    run_op(8'd0, 8'd8, 8'd24, 9'd4, 1'b0, dcyc, nw);
    check("fresh_result", 32'(result), 32'd70);
    check("fresh_reg24", 32'(regs[24]), 32'd70);
    check("fresh_done_cycle", 32'(dcyc), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
